// File: rtl/hsi_m_tx_arb.sv
// ---------------------------------------------------------------------------
// hsi_m_tx_arb -- transmit arbiter for the HSI master frame coder.
//
// Five requesters compete for the transmit path.  Fixed priority is
// TM > BTC > low group {SR, DPR, CCW}.  A winner owns the coder until the
// coder reports frame_done.  An inter-frame gap of GAP_TICKS enabled cycles
// then follows before the next decision.  During the gap, reply_win flags
// which low-group command (if any) owned the frame just completed.
//
// Optional feature (macro HSI_TX_ARB_RR_EN):
//   defined   -> the low group is round-robin (SR -> DPR -> CCW -> SR).
//   undefined -> the low group is fixed priority SR > DPR > CCW.
//
// Parameters:
//   GAP_TICKS   inter-frame gap length in enabled clk cycles (1..8191)
//
// Ports:
//   clk         system clock, rising edge
//   n_rst       asynchronous active-low reset
//   en          advance qualifier; nothing changes on edges with en=0
//   req[4:0]    level-held requests: [0]=TM [1]=BTC [2]=SR [3]=DPR [4]=CCW
//   mask[4:0]   per-requester enable, same bit order
//   pre_tm      when 1, CCW is not eligible
//   frame_done  one-cycle pulse at end of the current frame's CRC
//   gnt[4:0]    registered one-hot grant
//   busy        high while a grant or the gap is in progress
//   reply_win   one-hot [0]=SR [1]=DPR [2]=CCW, high during the gap
//               following that command's frame
//   reply_end   one-cycle pulse on the last gap cycle when reply_win != 0
// ---------------------------------------------------------------------------
module hsi_m_tx_arb #(
    parameter int GAP_TICKS = 100
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       en,
    input  logic [4:0] req,
    input  logic [4:0] mask,
    input  logic       pre_tm,
    input  logic       frame_done,
    output logic [4:0] gnt,
    output logic       busy,
    output logic [2:0] reply_win,
    output logic       reply_end
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Terminal count of the gap counter.
    localparam logic [12:0] GAP_LAST = 13'(GAP_TICKS - 1);

    state_t      state_r;
    logic [12:0] cnt_r;
    logic [4:0]  gnt_r;
    logic        busy_r;
    logic [2:0]  reply_win_r;
    logic        reply_end_r;

    logic [4:0]  elig_s;
    logic [2:0]  low_win_s;
    logic [4:0]  win_s;

`ifdef HSI_TX_ARB_RR_EN
    // Low-group index where the next search starts: 0=SR, 1=DPR, 2=CCW.
    logic [1:0]  rr_ptr_r;
    logic [2:0]  rot_s;
    logic [2:0]  rot_win_s;
`endif

    // First set bit of a 3-bit vector, bit 0 highest priority.
    function automatic logic [2:0] pick_first(input logic [2:0] v);
        logic [2:0] r;
        if (v[0]) begin
            r = 3'b001;
        end else if (v[1]) begin
            r = 3'b010;
        end else if (v[2]) begin
            r = 3'b100;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Eligibility and winner selection for the next IDLE decision.
    always_comb begin
        elig_s    = req & mask & {~pre_tm, 4'b1111};
        low_win_s = 3'b000;
`ifdef HSI_TX_ARB_RR_EN
        // Rotate the low group so the search start sits at bit 0, pick the
        // first request, then rotate the one-hot result back.
        rot_s     = 3'b000;
        rot_win_s = 3'b000;
        case (rr_ptr_r)
            2'd0: begin
                rot_s     = elig_s[4:2];
                rot_win_s = pick_first(rot_s);
                low_win_s = rot_win_s;
            end
            2'd1: begin
                rot_s     = {elig_s[2], elig_s[4], elig_s[3]};
                rot_win_s = pick_first(rot_s);
                low_win_s = {rot_win_s[1], rot_win_s[0], rot_win_s[2]};
            end
            2'd2: begin
                rot_s     = {elig_s[3], elig_s[2], elig_s[4]};
                rot_win_s = pick_first(rot_s);
                low_win_s = {rot_win_s[0], rot_win_s[2], rot_win_s[1]};
            end
            default: begin
                rot_s     = elig_s[4:2];
                rot_win_s = pick_first(rot_s);
                low_win_s = rot_win_s;
            end
        endcase
`else
        low_win_s = pick_first(elig_s[4:2]);
`endif
        if (elig_s[0]) begin
            win_s = 5'b00001;
        end else if (elig_s[1]) begin
            win_s = 5'b00010;
        end else begin
            win_s = {low_win_s, 2'b00};
        end
    end

    // Arbiter FSM with registered outputs; everything holds when en=0.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r     <= IDLE;
            cnt_r       <= 13'd0;
            gnt_r       <= 5'b00000;
            busy_r      <= 1'b0;
            reply_win_r <= 3'b000;
            reply_end_r <= 1'b0;
`ifdef HSI_TX_ARB_RR_EN
            rr_ptr_r    <= 2'd0;
`endif
        end else if (en) begin
            case (state_r)
                IDLE: begin
                    if (win_s != 5'b00000) begin
                        state_r <= GRANT;
                        gnt_r   <= win_s;
                        busy_r  <= 1'b1;
`ifdef HSI_TX_ARB_RR_EN
                        // Next search starts after the member just granted.
                        if (win_s[2]) begin
                            rr_ptr_r <= 2'd1;
                        end else if (win_s[3]) begin
                            rr_ptr_r <= 2'd2;
                        end else if (win_s[4]) begin
                            rr_ptr_r <= 2'd0;
                        end else begin
                            rr_ptr_r <= rr_ptr_r;
                        end
`endif
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (frame_done) begin
                        state_r     <= GAP;
                        gnt_r       <= 5'b00000;
                        cnt_r       <= 13'd0;
                        reply_win_r <= gnt_r[4:2];
                        // A one-cycle gap is also its own last cycle.
                        reply_end_r <= (GAP_LAST == 13'd0) && (gnt_r[4:2] != 3'b000);
                    end else begin
                        state_r <= GRANT;
                    end
                end
                GAP: begin
                    if (cnt_r == GAP_LAST) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        reply_win_r <= 3'b000;
                        reply_end_r <= 1'b0;
                    end else begin
                        cnt_r       <= cnt_r + 13'd1;
                        reply_end_r <= ((cnt_r + 13'd1) == GAP_LAST) && (reply_win_r != 3'b000);
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cnt_r       <= 13'd0;
                    gnt_r       <= 5'b00000;
                    busy_r      <= 1'b0;
                    reply_win_r <= 3'b000;
                    reply_end_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign busy      = busy_r;
    assign reply_win = reply_win_r;
    assign reply_end = reply_end_r;

endmodule

// File: tb/tb_hsi_m_tx_arb.sv
// ---------------------------------------------------------------------------
// tb_hsi_m_tx_arb -- self-checking bench for hsi_m_tx_arb (GAP_TICKS=4).
// A transaction-level model (current owner, remaining gap position, reply
// owner) predicts every output; a negedge process compares it each cycle.
// Directed sequences add literal expectations that pin the model.
// ---------------------------------------------------------------------------
module tb_hsi_m_tx_arb;

    localparam int GAP = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       en = 1'b0;
    logic [4:0] req = 5'b00000;
    logic [4:0] mask = 5'b11111;
    logic       pre_tm = 1'b0;
    logic       frame_done = 1'b0;
    logic [4:0] gnt;
    logic       busy;
    logic [2:0] reply_win;
    logic       reply_end;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    hsi_m_tx_arb #(.GAP_TICKS(GAP)) dut (
        .clk(clk), .n_rst(n_rst), .en(en), .req(req), .mask(mask),
        .pre_tm(pre_tm), .frame_done(frame_done), .gnt(gnt), .busy(busy),
        .reply_win(reply_win), .reply_end(reply_end)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_owner;   // -1: nobody owns the coder, else requester index 0..4
    bit m_in_gap;
    int m_gap_pos; // number of gap cycles already elapsed
    int m_reply;   // -1 or low-group index 0..2 of the finished frame
    int m_rr;      // low-group index where the next search starts

    function automatic int choose(input logic [4:0] r, input logic [4:0] m,
                                  input logic p, input int start);
        logic [4:0] e;
        e = r & m;
        if (p) e[4] = 1'b0;
        if (e[0]) return 0;
        if (e[1]) return 1;
        for (int k = 0; k < 3; k++) begin
            int j;
            j = (start + k) % 3;
            if (e[2 + j]) return 2 + j;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            m_owner = -1; m_in_gap = 1'b0; m_gap_pos = 0; m_reply = -1; m_rr = 0;
        end else if (en) begin
            if (m_owner >= 0) begin
                if (frame_done) begin
                    m_in_gap  = 1'b1;
                    m_gap_pos = 0;
                    m_reply   = (m_owner >= 2) ? m_owner - 2 : -1;
                    m_owner   = -1;
                end
            end else if (m_in_gap) begin
                if (m_gap_pos == GAP - 1) begin
                    m_in_gap = 1'b0;
                    m_reply  = -1;
                end else begin
                    m_gap_pos++;
                end
            end else begin
                int w;
`ifdef HSI_TX_ARB_RR_EN
                w = choose(req, mask, pre_tm, m_rr);
                if (w >= 2) m_rr = (w - 2 + 1) % 3;
`else
                w = choose(req, mask, pre_tm, 0);
`endif
                m_owner = w;
            end
        end
    end

    function automatic logic [4:0] exp_gnt();
        return (m_owner >= 0) ? 5'(1 << m_owner) : 5'b00000;
    endfunction
    function automatic logic [2:0] exp_rw();
        return (m_in_gap && m_reply >= 0) ? 3'(1 << m_reply) : 3'b000;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("mdl_gnt", 8'(gnt), 8'(exp_gnt()));
            chk("mdl_busy", 8'(busy), 8'(m_owner >= 0 || m_in_gap));
            chk("mdl_reply_win", 8'(reply_win), 8'(exp_rw()));
            chk("mdl_reply_end", 8'(reply_end),
                8'(m_in_gap && m_reply >= 0 && m_gap_pos == GAP - 1));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_done();
        frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
    endtask

    initial begin
        logic [4:0] rr_exp [3];
        cyc(2);
        cmp_on = 1'b1;
        chk("rst_gnt", 8'(gnt), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_reply_win", 8'(reply_win), 8'h00);
        chk("rst_reply_end", 8'(reply_end), 8'h00);
        n_rst = 1'b1;
        en    = 1'b1;

        // TM beats SR; gap after a TM frame has no reply window.
        req = 5'b00101;
        cyc(1);
        chk("tm_first", 8'(gnt), 8'h01);
        cyc(3);
        chk("tm_hold", 8'(gnt), 8'h01);
        req = 5'b00100;
        pulse_done();
        chk("gap0_gnt", 8'(gnt), 8'h00);
        chk("gap0_busy", 8'(busy), 8'h01);
        chk("gap0_rw", 8'(reply_win), 8'h00);
        cyc(3);
        chk("tm_gap_no_end", 8'(reply_end), 8'h00);
        cyc(1);
        chk("gap_over_busy", 8'(busy), 8'h00);
        cyc(1);
        chk("sr_after_gap", 8'(gnt), 8'h04);

        // SR frame: reply window for SR, end pulse on the last gap cycle.
        req = 5'b00000;
        pulse_done();
        chk("sr_rw", 8'(reply_win), 8'h01);
        cyc(3);
        chk("sr_end", 8'(reply_end), 8'h01);
        cyc(1);
        chk("sr_end_clear", 8'(reply_end), 8'h00);

        // pre_tm blocks CCW; pre_tm change during GRANT is ignored.
        req = 5'b10000; pre_tm = 1'b1;
        cyc(3);
        chk("pretm_block", 8'(gnt), 8'h00);
        pre_tm = 1'b0;
        cyc(1);
        chk("ccw_grant", 8'(gnt), 8'h10);
        pre_tm = 1'b1;
        cyc(2);
        chk("ccw_hold_pretm", 8'(gnt), 8'h10);
        pre_tm = 1'b0; req = 5'b00000;
        pulse_done();
        chk("ccw_rw", 8'(reply_win), 8'h04);
        cyc(3);
        chk("ccw_end", 8'(reply_end), 8'h01);
        cyc(1);

        // en=0 freezes the gap mid-way.
        req = 5'b01000;
        cyc(1);
        chk("dpr_grant", 8'(gnt), 8'h08);
        req = 5'b00000;
        pulse_done();
        cyc(1);
        en = 1'b0;
        cyc(5);
        chk("frz_rw", 8'(reply_win), 8'h02);
        chk("frz_busy", 8'(busy), 8'h01);
        chk("frz_end", 8'(reply_end), 8'h00);
        en = 1'b1;
        cyc(2);
        chk("frz_done_end", 8'(reply_end), 8'h01);
        cyc(1);
        chk("frz_idle", 8'(busy), 8'h00);

        // frame_done in IDLE is ignored; frame_done on the grant edge too.
        pulse_done();
        chk("done_idle", 8'(busy), 8'h00);
        req = 5'b00010; frame_done = 1'b1;
        cyc(1);
        frame_done = 1'b0;
        chk("btc_grant", 8'(gnt), 8'h02);
        req = 5'b00000;
        cyc(3);
        chk("btc_hold_req_drop", 8'(gnt), 8'h02);
        pulse_done();
        chk("btc_rw", 8'(reply_win), 8'h00);
        cyc(4);

        // Masked SR loses to DPR.
        req = 5'b11100; mask = 5'b11011;
        cyc(1);
        chk("mask_sr", 8'(gnt[2]), 8'h00);
        pulse_done();
        cyc(4);
        mask = 5'b11111;

        // Reset the pointer, then three frames with all low members asking.
        n_rst = 1'b0;
        cyc(1);
        n_rst = 1'b1;
`ifdef HSI_TX_ARB_RR_EN
        rr_exp[0] = 5'b00100; rr_exp[1] = 5'b01000; rr_exp[2] = 5'b10000;
`else
        rr_exp[0] = 5'b00100; rr_exp[1] = 5'b00100; rr_exp[2] = 5'b00100;
`endif
        for (int f = 0; f < 3; f++) begin
            cyc(1);
            chk($sformatf("low_frame%0d", f), 8'(gnt), 8'(rr_exp[f]));
            cyc(2);
            pulse_done();
            cyc(4);
        end

        // Asynchronous reset in the middle of a DPR frame.
        req = 5'b01000;
        cyc(1);
        chk("dpr_pre_rst", 8'(gnt), 8'h08);
        cyc(2);
        n_rst = 1'b0;
        #1;
        chk("async_rst_gnt", 8'(gnt), 8'h00);
        chk("async_rst_busy", 8'(busy), 8'h00);
        cyc(2);
        n_rst = 1'b1;
        cyc(1);
        chk("post_rst_grant", 8'(gnt), 8'h08);
        req = 5'b00000;
        pulse_done();
        cyc(5);

        cmp_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
